// File: rtl/cache_miss_ctrl.sv
// Miss handler for the fully associative cache: stalls the CPU on a miss,
// writes back a dirty victim, fills the line from memory and installs it.
module cache_miss_ctrl #(
   parameter int DATAW   = 32,
   parameter int TAGW    = 6,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             req_write,
   input  logic [TAGW-1:0]  req_tag,
   input  logic [DATAW-1:0] req_data,
   input  logic             hit,
   input  logic             victim_dirty,
   input  logic [TAGW-1:0]  victim_tag,
   input  logic [DATAW-1:0] victim_data,
   output logic             stall,
   output logic             cache_wr_en,
   output logic [TAGW-1:0]  cache_wr_tag,
   output logic [DATAW-1:0] cache_wr_data,
   output logic             cache_wr_dirty,
   output logic             mem_req,
   output logic             mem_we,
   output logic [TAGW-1:0]  mem_addr,
   output logic [DATAW-1:0] mem_wdata,
   input  logic             mem_ready,
   input  logic [DATAW-1:0] mem_rdata,
   output logic             err
);

   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_UPDATE,
      S_ERR
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_write;
   logic [TAGW-1:0]    r_tag;
   logic [DATAW-1:0]   r_data;
   logic [TAGW-1:0]    r_vtag;
   logic [DATAW-1:0]   r_vdata;
   logic [DATAW-1:0]   r_rdata;
   logic [CNTW-1:0]    r_cnt;
   logic               w_miss;
   logic               w_timeout;

   assign w_miss    = req & ~hit;
   // The wait that would push the counter to TIMEOUT is the last one allowed.
   assign w_timeout = ~mem_ready & (r_cnt == CNTW'(TIMEOUT - 1));

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Latch the missing request, the dirty victim and the returned fill data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
         r_vtag  <= '0;
         r_vdata <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == S_IDLE && w_miss) begin
            r_write <= req_write;
            r_tag   <= req_tag;
            r_data  <= req_data;
            if (victim_dirty) begin
               r_vtag  <= victim_tag;
               r_vdata <= victim_data;
            end
         end
         if (r_state == S_FILL && mem_ready) r_rdata <= mem_rdata;
      end
   end

   // Memory wait counter: zero outside WB/FILL and after each accepted access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_WB, S_FILL: r_cnt <= mem_ready ? '0 : r_cnt + CNTW'(1);
            default:      r_cnt <= '0;
         endcase
      end
   end

   // Next-state selection.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_miss) w_next = victim_dirty ? S_WB : S_FILL;
         end
         S_WB: begin
            if (mem_ready)      w_next = S_FILL;
            else if (w_timeout) w_next = S_ERR;
         end
         S_FILL: begin
            if (mem_ready)      w_next = S_UPDATE;
            else if (w_timeout) w_next = S_ERR;
         end
         S_UPDATE: w_next = S_IDLE;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_IDLE;
      endcase
   end

   // Output decode; stall also covers the miss cycle itself.
   always_comb begin
      stall          = 1'b0;
      cache_wr_en    = 1'b0;
      cache_wr_tag   = '0;
      cache_wr_data  = '0;
      cache_wr_dirty = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      err            = 1'b0;
      case (r_state)
         S_IDLE: stall = w_miss;
         S_WB: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_vtag;
            mem_wdata = r_vdata;
         end
         S_FILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = r_tag;
         end
         S_UPDATE: begin
            stall          = 1'b1;
            cache_wr_en    = 1'b1;
            cache_wr_tag   = r_tag;
            cache_wr_data  = r_write ? r_data : r_rdata;
            cache_wr_dirty = r_write;
         end
         S_ERR: begin
            stall = 1'b1;
            err   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed table, randomized miss transactions
// expanded into per-cycle expectations, plus timeout and async-reset sequences.
module tb_cache_miss_ctrl;

   localparam int TO = 8;

   logic        clk;
   logic        rst;
   logic        req, req_write, hit, victim_dirty, mem_ready;
   logic [5:0]  req_tag, victim_tag;
   logic [31:0] req_data, victim_data, mem_rdata;
   logic        stall, cache_wr_en, cache_wr_dirty, mem_req, mem_we, err;
   logic [5:0]  cache_wr_tag, mem_addr;
   logic [31:0] cache_wr_data, mem_wdata;

   cache_miss_ctrl #(.DATAW(32), .TAGW(6), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req(req), .req_write(req_write), .req_tag(req_tag), .req_data(req_data),
      .hit(hit), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .victim_data(victim_data),
      .stall(stall), .cache_wr_en(cache_wr_en), .cache_wr_tag(cache_wr_tag),
      .cache_wr_data(cache_wr_data), .cache_wr_dirty(cache_wr_dirty),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [5:0]  tag;
      logic [31:0] data;
      logic        hit;
      logic        vd;
      logic [5:0]  vtag;
      logic [31:0] vdata;
      logic        mrdy;
      logic [31:0] mrdata;
   } in_t;

   typedef struct packed {
      logic        stall;
      logic        mreq;
      logic        mwe;
      logic [5:0]  maddr;
      logic [31:0] mwdata;
      logic        wen;
      logic [5:0]  wtag;
      logic [31:0] wdata;
      logic        wdirty;
      logic        err;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   // ---------------- expected-output builders ----------------
   function automatic out_t o_none();
      out_t o = '0;
      return o;
   endfunction

   function automatic out_t o_miss();
      out_t o = '0;
      o.stall = 1'b1;
      return o;
   endfunction

   function automatic out_t o_wb(logic [5:0] a, logic [31:0] d);
      out_t o = '0;
      o.stall = 1'b1; o.mreq = 1'b1; o.mwe = 1'b1; o.maddr = a; o.mwdata = d;
      return o;
   endfunction

   function automatic out_t o_fill(logic [5:0] a);
      out_t o = '0;
      o.stall = 1'b1; o.mreq = 1'b1; o.maddr = a;
      return o;
   endfunction

   function automatic out_t o_upd(logic [5:0] t, logic [31:0] d, logic dirty);
      out_t o = '0;
      o.stall = 1'b1; o.wen = 1'b1; o.wtag = t; o.wdata = d; o.wdirty = dirty;
      return o;
   endfunction

   function automatic out_t o_err();
      out_t o = '0;
      o.stall = 1'b1; o.err = 1'b1;
      return o;
   endfunction

   // ---------------- input builders ----------------
   // Random values on every input the controller must ignore in this cycle.
   function automatic in_t junk(logic mrdy, logic [31:0] mrdata);
      in_t v;
      v.req    = 1'($urandom);
      v.wr     = 1'($urandom);
      v.tag    = 6'($urandom);
      v.data   = $urandom;
      v.hit    = 1'($urandom);
      v.vd     = 1'($urandom);
      v.vtag   = 6'($urandom);
      v.vdata  = $urandom;
      v.mrdy   = mrdy;
      v.mrdata = mrdata;
      return v;
   endfunction

   function automatic in_t idle_in(logic rq);
      in_t v = junk(1'($urandom), $urandom);
      v.req = rq;
      v.hit = rq ? 1'b1 : 1'($urandom);
      return v;
   endfunction

   function automatic in_t miss_in(logic wr, logic [5:0] tag, logic [31:0] data,
                                   logic vd, logic [5:0] vtag, logic [31:0] vdata);
      in_t v = junk(1'($urandom), $urandom);
      v.req = 1'b1; v.wr = wr; v.tag = tag; v.data = data; v.hit = 1'b0;
      v.vd = vd; v.vtag = vtag; v.vdata = vdata;
      return v;
   endfunction

   task automatic push(input in_t i, input out_t o);
      vec_t v;
      v.i = i;
      v.o = o;
      vecs.push_back(v);
   endtask

   // Expands one miss transaction into cycles: miss, optional write-back with
   // dw wait cycles, fill with df wait cycles, install.
   task automatic gen_miss(input logic wr, input logic [5:0] tag, input logic [31:0] data,
                           input logic vd, input logic [5:0] vtag, input logic [31:0] vdata,
                           input int dw, input int df, input logic [31:0] rdata);
      push(miss_in(wr, tag, data, vd, vtag, vdata), o_miss());
      if (vd) begin
         for (int k = 0; k < dw; k++) push(junk(1'b0, $urandom), o_wb(vtag, vdata));
         push(junk(1'b1, $urandom), o_wb(vtag, vdata));
      end
      for (int k = 0; k < df; k++) push(junk(1'b0, $urandom), o_fill(tag));
      push(junk(1'b1, rdata), o_fill(tag));
      push(junk(1'($urandom), $urandom), o_upd(tag, wr ? data : rdata, wr));
   endtask

   // ---------------- drive / sample / compare ----------------
   task automatic drive(input in_t v);
      req = v.req; req_write = v.wr; req_tag = v.tag; req_data = v.data;
      hit = v.hit; victim_dirty = v.vd; victim_tag = v.vtag; victim_data = v.vdata;
      mem_ready = v.mrdy; mem_rdata = v.mrdata;
   endtask

   function automatic out_t sample();
      out_t o;
      o.stall = stall; o.mreq = mem_req; o.mwe = mem_we; o.maddr = mem_addr;
      o.mwdata = mem_wdata; o.wen = cache_wr_en; o.wtag = cache_wr_tag;
      o.wdata = cache_wr_data; o.wdirty = cache_wr_dirty; o.err = err;
      return o;
   endfunction

   // Payload fields matter only while their strobe is expected high.
   function automatic out_t mask(out_t x, out_t e);
      out_t m = x;
      if (!e.mreq) begin m.mwe = 1'b0; m.maddr = '0; end
      if (!(e.mreq && e.mwe)) m.mwdata = '0;
      if (!e.wen) begin m.wtag = '0; m.wdata = '0; m.wdirty = 1'b0; end
      return m;
   endfunction

   task automatic check(input out_t e, input string nm);
      out_t a = mask(sample(), e);
      out_t x = mask(e, e);
      tests++;
      if (a !== x) begin
         fails++;
         $display("FAIL %s @%0t: got stall=%b mreq=%b mwe=%b maddr=%h mwdata=%h wen=%b wtag=%h wdata=%h wdirty=%b err=%b ; expected stall=%b mreq=%b mwe=%b maddr=%h mwdata=%h wen=%b wtag=%h wdata=%h wdirty=%b err=%b",
                  nm, $time, a.stall, a.mreq, a.mwe, a.maddr, a.mwdata, a.wen, a.wtag, a.wdata, a.wdirty, a.err,
                  x.stall, x.mreq, x.mwe, x.maddr, x.mwdata, x.wen, x.wtag, x.wdata, x.wdirty, x.err);
      end
   endtask

   // Called at posedge+1: drive, check at negedge, advance to next posedge+1.
   task automatic apply(input in_t i, input out_t o, input string nm);
      drive(i);
      @(negedge clk);
      check(o, nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dw, df;
      in_t z;
      z = '0;
      drive(z);
      rst = 1'b1;

      // Directed table: clean read miss (tag 0x05, data ready on fill's first
      // cycle) followed by idle/hit cycles showing stall lasted exactly 3.
      push(idle_in(1'b1), o_none());
      push(miss_in(1'b0, 6'h05, 32'h0, 1'b0, 6'h3F, 32'h0), o_miss());
      push(junk(1'b1, 32'hDEADBEEF), o_fill(6'h05));
      push(junk(1'b0, 32'h0), o_upd(6'h05, 32'hDEADBEEF, 1'b0));
      push(idle_in(1'b1), o_none());
      push(idle_in(1'b1), o_none());
      push(idle_in(1'b0), o_none());
      // Dirty write miss: write-back held 4 cycles, then fill, install dirty.
      gen_miss(1'b1, 6'h12, 32'h1234, 1'b1, 6'h07, 32'hCAFE, 3, 0, 32'h5555AAAA);
      push(idle_in(1'b0), o_none());
      // Ready arriving in the last allowed cycle of both phases.
      gen_miss(1'b0, 6'h2A, 32'h0, 1'b1, 6'h11, 32'h0BAD_F00D, TO - 1, TO - 1, 32'h8765_4321);
      push(idle_in(1'b1), o_none());
      // Randomized transactions interleaved with hit / idle cycles.
      for (int t = 0; t < 40; t++) begin
         dw = int'($urandom_range(0, TO - 1));
         df = int'($urandom_range(0, TO - 1));
         gen_miss(1'($urandom), 6'($urandom), $urandom, 1'($urandom), 6'($urandom),
                  $urandom, dw, df, $urandom);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            push(idle_in(1'($urandom)), o_none());
      end

      // Reset state.
      @(posedge clk);
      #1;
      @(negedge clk);
      check(o_none(), "reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i].i, vecs[i].o, $sformatf("vec%0d", i));

      // Timeout in fill: 8 waiting cycles, then sticky error even with ready.
      apply(miss_in(1'b0, 6'h33, 32'h0, 1'b0, 6'h0, 32'h0), o_miss(), "to_miss");
      for (int k = 0; k < TO; k++)
         apply(junk(1'b0, $urandom), o_fill(6'h33), $sformatf("to_fill%0d", k));
      for (int k = 0; k < 4; k++)
         apply(junk(1'($urandom), $urandom), o_err(), $sformatf("to_err%0d", k));

      // Async reset out of the error state.
      drive(z);
      #2 rst = 1'b1;
      #1 check(o_none(), "rst_from_err");
      @(posedge clk);
      #1 rst = 1'b0;

      // Async reset mid-fill drops everything before the next clock edge.
      apply(miss_in(1'b1, 6'h09, 32'h77, 1'b0, 6'h0, 32'h0), o_miss(), "mf_miss");
      apply(junk(1'b0, $urandom), o_fill(6'h09), "mf_fill0");
      apply(junk(1'b0, $urandom), o_fill(6'h09), "mf_fill1");
      drive(z);
      #2 rst = 1'b1;
      #1 check(o_none(), "rst_mid_fill");
      @(posedge clk);
      #1 rst = 1'b0;
      apply(idle_in(1'b0), o_none(), "after_rst_idle");

      // Normal operation resumes after reset.
      vecs.delete();
      gen_miss(1'b0, 6'h01, 32'h0, 1'b0, 6'h0, 32'h0, 0, 2, 32'h1357_9BDF);
      push(idle_in(1'b1), o_none());
      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i].i, vecs[i].o, $sformatf("post%0d", i));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Memory-side miss handler paired with the fully associative cache.
- On a CPU request that misses, it stalls the requester and writes back the dirty victim line if needed.
- It then fills the line from backing memory and writes it into the cache through the cache's insert port.
- Sits between the cache array and the backing memory; the CPU replays the request after stall drops.

Parameters:
- DATAW, 32, data word width (one word per line).
- TAGW, 6, tag width; the tag is also the memory word address.
- TIMEOUT, 255, maximum cycles waiting on mem_ready before the error state; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- req  input  1  CPU request valid (cache enable)
- req_write  input  1  1 = write, 0 = read
- req_tag  input  TAGW  requested tag
- req_data  input  DATAW  write data
- hit  input  1  cache lookup hit (valid && tag match) for current req_tag
- victim_dirty  input  1  line at cache insert index is valid and dirty
- victim_tag  input  TAGW  tag of the victim line
- victim_data  input  DATAW  data of the victim line
- stall  output  1  hold the CPU request
- cache_wr_en  output  1  one-cycle cache line write strobe
- cache_wr_tag  output  TAGW  tag to install
- cache_wr_data  output  DATAW  data to install
- cache_wr_dirty  output  1  dirty bit to install
- mem_req  output  1  memory request valid
- mem_we  output  1  memory write enable
- mem_addr  output  TAGW  memory address
- mem_wdata  output  DATAW  memory write data
- mem_ready  input  1  memory accepts the write / returns read data this cycle
- mem_rdata  input  DATAW  read data, valid when mem_ready && !mem_we
- err  output  1  sticky memory timeout flag

Behaviour:
- States: IDLE, WB, FILL, UPDATE, ERR.
- Reset (async, immediate): state=IDLE; all outputs 0; latched tag/data/write and timeout counter cleared. Reset mid-transaction abandons it; mem_req drops in the same cycle rst rises.
- stall = (state != IDLE) | (req & ~hit & state == IDLE). This is combinational so the CPU sees stall in the miss cycle.
- IDLE:
  - req & hit: no action; the cache handles the hit itself.
  - req & ~hit: latch req_tag, req_data and req_write.
  - If victim_dirty, latch victim_tag/victim_data and go to WB; else go to FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr=latched victim tag, mem_wdata=latched victim data.
  - Outputs are held stable until mem_ready is sampled high, then go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=latched req tag.
  - On mem_ready, capture mem_rdata and go to UPDATE.
- UPDATE:
  - cache_wr_en=1 for exactly one cycle; cache_wr_tag=latched tag.
  - If the latched op is a write: cache_wr_data=latched req_data, cache_wr_dirty=1 (write-allocate).
  - Else: cache_wr_data=captured mem_rdata, cache_wr_dirty=0.
  - Next state IDLE; stall falls the following cycle.
- Minimum miss latency, clean victim with mem_ready already high: miss cycle, FILL, UPDATE, giving 3 cycles of stall. A dirty victim adds at least 1 cycle.
- Inputs req*, hit and victim* are ignored outside IDLE.
- Timeout:
  - Counter clears on entry to WB or FILL and increments each cycle mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to ERR.
  - mem_ready high in the TIMEOUT-th cycle completes normally.
- ERR: mem_req=0, stall=1, err=1; leaves only on rst.
- mem_req is never asserted in IDLE/UPDATE/ERR. cache_wr_en is never asserted outside UPDATE.

Test Plan:
- Reset: rst pulse mid-FILL → next sample shows state IDLE, stall=0, mem_req=0, err=0, cache_wr_en=0.
- Clean read miss: req=1, write=0, tag=0x05, hit=0, victim_dirty=0; mem_ready=1 with rdata=0xDEADBEEF on second cycle → mem_addr=0x05, mem_we=0; then cache_wr_en pulse with tag 0x05, data 0xDEADBEEF, dirty=0; stall exactly 3 cycles.
- Dirty write miss: tag=0x12, data=0x1234, victim tag 0x07 data 0xCAFE dirty; mem_ready delayed 4 cycles → WB write (addr 0x07, wdata 0xCAFE) held 4 cycles, then FILL read of addr 0x12, then install tag 0x12, data 0x1234, dirty=1.
- Hit: req=1, hit=1 → stall=0, mem_req=0, cache_wr_en=0 throughout.
- Timeout: TIMEOUT=8, miss with mem_ready stuck 0 → ERR after 8 FILL cycles; err=1, stall=1, mem_req=0 until rst. Repeat with mem_ready=1 on cycle 8 → normal completion, err=0.
